dp_ram: RTL and testbench
=========================

DP_RAM -- requirements
Module: dp_ram

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits.
REQ-002 Parameter ADDR_W, default 12, address width; DEPTH = 2**ADDR_W words (4096 by default).
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data  input  DATA_W  write data.
REQ-006 wraddress  input  ADDR_W  write address.
REQ-007 wren  input  1  write enable.
REQ-008 rdaddress  input  ADDR_W  read address.
REQ-009 rden  input  1  read enable.
REQ-010 q  output  DATA_W  registered read data.

Function
REQ-011 Simple dual-port memory: one write port and one read port, fully independent, both usable in the same cycle.
REQ-012 Write: at a rising edge with wren=1, mem[wraddress] SHALL take data; with wren=0 memory is unchanged.
REQ-013 Read: at a rising edge with rden=1, q SHALL take mem[rdaddress]; read latency is exactly 1 clock (address presented in cycle N, data on q in cycle N+1).
REQ-014 With rden=0, q SHALL hold its previous value.
REQ-015 Addresses are used at full ADDR_W width; no out-of-range access exists and no wrap logic is needed.
REQ-016 Same-address read-during-write (rden=1, wren=1, rdaddress=wraddress), macro absent: q SHALL return the old (pre-write) contents; the new data is visible to a read in the following cycle.
REQ-017 Different-address simultaneous read and write SHALL not interact.
REQ-018 Memory contents SHALL be all-zero at power-up (initialisation, not reset).
REQ-019 No handshake; reads and writes accepted every cycle, no back-pressure, no stall.

Reset
REQ-020 While reset=1 at a rising edge, q SHALL become 0, overriding rden.
REQ-021 Reset SHALL NOT alter memory contents.
REQ-022 A write with wren=1 during a reset cycle SHALL still be performed.
REQ-023 Reset asserted between an address cycle and its data cycle SHALL drop that read; q=0 after reset, and the next rden=1 cycle resumes normal 1-cycle latency.

Configuration
REQ-024 Macro DP_RAM_WRITE_THROUGH_EN: when defined, a same-address read-during-write SHALL return the new data (write-forwarding mux on q input); when undefined, REQ-016 old-data behaviour applies. Latency and all other behaviour are identical in both builds.

Verification
REQ-025 Write 0xDEADBEEF to address 5; next cycle rden=1, rdaddress=5 -> q=0xDEADBEEF exactly one clock later.
REQ-026 Fresh power-up, read address 4095 -> q=0; write 0x1 to 4095, read back -> q=0x1.
REQ-027 mem[7]=0xA; same cycle wren=1, data=0xB, wraddress=7, rden=1, rdaddress=7 -> q=0xA (macro absent) or 0xB (macro defined); next read of 7 -> 0xB in both builds.
REQ-028 Read 0x55 from address 3, then hold rden=0 for 3 cycles while writing elsewhere -> q stays 0x55.
REQ-029 q=0x1234 with memory loaded; pulse reset for one cycle -> q=0; re-read the same address -> original data (contents preserved).
REQ-030 Back-to-back writes to addresses 0..15 then back-to-back reads 0..15 -> q streams the written values, one per cycle, each one cycle after its address.

Source files
------------

// File: rtl/dp_ram_if.sv
`default_nettype none
// ============================================================================
//  Module      : dp_ram_if
//  Description : Bus bundle for the simple dual-port RAM. Carries one write
//                port (data/wraddress/wren) and one read port
//                (rdaddress/rden/q). The master drives addresses, data and
//                enables. The slave (the RAM) returns q.
//  Revision    : 1.0  initial release
// ============================================================================
interface dp_ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] wraddress;
    logic              wren;
    logic [ADDR_W-1:0] rdaddress;
    logic              rden;
    logic [DATA_W-1:0] q;

    modport master (
        output data,
        output wraddress,
        output wren,
        output rdaddress,
        output rden,
        input  q
    );

    modport slave (
        input  data,
        input  wraddress,
        input  wren,
        input  rdaddress,
        input  rden,
        output q
    );
endinterface
`default_nettype wire

// File: rtl/dp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dp_ram
//  Description : Simple dual-port RAM with one write port and one read port on
//                a single clock. Read data is registered, so q is valid one
//                clock after the address cycle. Memory powers up all-zero.
//                Reset clears only q and leaves memory untouched.
//  Options     : DP_RAM_WRITE_THROUGH_EN. When it is defined, a same-address
//                read-during-write returns the new data. When it is not
//                defined, the read returns the old data.
//  Revision    : 1.0  initial release
// ============================================================================
module dp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  wire logic   clock,
    input  wire logic   reset,
    dp_ram_if.slave     bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    // The storage array is initialised to zero at configuration time. Reset
    // is never applied to it.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] q_d;
    logic [DATA_W-1:0] q_q;

    // Selects the word seen by the read port in this cycle.
    always_comb begin
        rd_word = mem[bus.rdaddress];
`ifdef DP_RAM_WRITE_THROUGH_EN
        // Forward the incoming write data when both ports hit the same word.
        if (bus.wren && (bus.wraddress == bus.rdaddress)) begin
            rd_word = bus.data;
        end
`endif
    end

    // q loads a new value only on a read. Otherwise it holds.
    always_comb begin
        q_d = q_q;
        if (bus.rden) begin
            q_d = rd_word;
        end
    end

    // Output register. Reset takes priority over a pending read.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Write port. It ignores reset, so a write in a reset cycle still lands.
    always_ff @(posedge clock) begin
        if (bus.wren) begin
            mem[bus.wraddress] <= bus.data;
        end
    end

    assign bus.q = q_q;

endmodule
`default_nettype wire

// File: tb/tb_dp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dp_ram
//  Description : Self-checking bench for dp_ram. It runs directed scenarios
//                first and then random traffic. The expected values come from
//                a cycle-level memory model built from plain arrays.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dp_ram;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic clock = 1'b0;
    logic reset = 1'b0;

    dp_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_q;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus. Inputs change on the falling edge. The model
    // advances at the rising edge, and q is sampled 1 time unit later.
    task automatic cycle(input string tag,
                         input logic we, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd,
                         input logic re, input logic [ADDR_W-1:0] ra,
                         input logic rst);
        logic same;
        @(negedge clock);
        bus.wren      = we;
        bus.wraddress = wa;
        bus.data      = wd;
        bus.rden      = re;
        bus.rdaddress = ra;
        reset         = rst;
        @(posedge clock);
        same = we && (wa == ra);
        if (rst) begin
            exp_q = '0;
        end else if (re) begin
`ifdef DP_RAM_WRITE_THROUGH_EN
            exp_q = same ? wd : ref_mem[ra];
`else
            exp_q = ref_mem[ra];
`endif
        end
        if (we) begin
            ref_mem[wa] = wd;
        end
        #1;
        check_eq(tag, bus.q, exp_q);
    endtask

    initial begin
        logic [DATA_W-1:0] fixed_exp;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
        end
        exp_q         = '0;
        bus.wren      = 1'b0;
        bus.rden      = 1'b0;
        bus.data      = '0;
        bus.wraddress = '0;
        bus.rdaddress = '0;

        // Reset state
        cycle("reset_q", 1'b0, 12'd0, 32'd0, 1'b1, 12'd0, 1'b1);
        check_eq("reset_q_zero", bus.q, 32'd0);

        // Top address is zero at power-up, then takes a write
        cycle("rd4095_addr", 1'b0, 12'd0, 32'd0, 1'b1, 12'd4095, 1'b0);
        check_eq("rd4095_init", bus.q, 32'd0);
        cycle("wr4095", 1'b1, 12'd4095, 32'h1, 1'b0, 12'd0, 1'b0);
        cycle("rd4095_back", 1'b0, 12'd0, 32'd0, 1'b1, 12'd4095, 1'b0);
        check_eq("rd4095_val", bus.q, 32'h1);

        // Basic write, then read with one-cycle latency
        cycle("wr5", 1'b1, 12'd5, 32'hDEADBEEF, 1'b0, 12'd0, 1'b0);
        cycle("rd5", 1'b0, 12'd0, 32'd0, 1'b1, 12'd5, 1'b0);
        check_eq("rd5_val", bus.q, 32'hDEADBEEF);

        // Same-address read during write
        cycle("wr7_a", 1'b1, 12'd7, 32'hA, 1'b0, 12'd0, 1'b0);
        cycle("rdw7", 1'b1, 12'd7, 32'hB, 1'b1, 12'd7, 1'b0);
`ifdef DP_RAM_WRITE_THROUGH_EN
        fixed_exp = 32'hB;
`else
        fixed_exp = 32'hA;
`endif
        check_eq("rdw7_fixed", bus.q, fixed_exp);
        cycle("rd7_after", 1'b0, 12'd0, 32'd0, 1'b1, 12'd7, 1'b0);
        check_eq("rd7_new", bus.q, 32'hB);

        // Hold: rden low while writing elsewhere
        cycle("wr3", 1'b1, 12'd3, 32'h55, 1'b0, 12'd0, 1'b0);
        cycle("rd3", 1'b0, 12'd0, 32'd0, 1'b1, 12'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("hold", 1'b1, 12'(100 + i), 32'(32'h900 + i), 1'b0, 12'd3, 1'b0);
            check_eq("hold_55", bus.q, 32'h55);
        end

        // Reset clears q but keeps memory. A write during reset still lands.
        cycle("wr20", 1'b1, 12'd20, 32'h1234, 1'b0, 12'd0, 1'b0);
        cycle("rd20", 1'b0, 12'd0, 32'd0, 1'b1, 12'd20, 1'b0);
        check_eq("rd20_val", bus.q, 32'h1234);
        cycle("rst_pulse", 1'b1, 12'd21, 32'h77, 1'b1, 12'd20, 1'b1);
        check_eq("rst_q_zero", bus.q, 32'd0);
        cycle("rd20_again", 1'b0, 12'd0, 32'd0, 1'b1, 12'd20, 1'b0);
        check_eq("rd20_kept", bus.q, 32'h1234);
        cycle("rd21", 1'b0, 12'd0, 32'd0, 1'b1, 12'd21, 1'b0);
        check_eq("wr_in_reset", bus.q, 32'h77);

        // A reset between the address cycle and the data cycle drops the read
        cycle("rd5_pre", 1'b0, 12'd0, 32'd0, 1'b1, 12'd5, 1'b0);
        cycle("rst_drop", 1'b0, 12'd0, 32'd0, 1'b0, 12'd5, 1'b1);
        check_eq("drop_zero", bus.q, 32'd0);
        cycle("rd5_resume", 1'b0, 12'd0, 32'd0, 1'b1, 12'd5, 1'b0);
        check_eq("resume_val", bus.q, 32'hDEADBEEF);

        // Streaming: 16 writes followed by 16 reads
        for (int i = 0; i < 16; i++) begin
            cycle("stream_wr", 1'b1, 12'(i), 32'(32'hC0DE0000 + i * 3), 1'b0, 12'd0, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            cycle("stream_rd", 1'b0, 12'd0, 32'd0, 1'b1, 12'(i), 1'b0);
            check_eq("stream_val", bus.q, 32'(32'hC0DE0000 + i * 3));
        end

        // Random traffic over a small address window to force collisions
        for (int i = 0; i < 2000; i++) begin
            cycle("random",
                  ($urandom_range(0, 1) == 1),
                  12'($urandom_range(0, 31)),
                  32'($urandom),
                  ($urandom_range(0, 2) != 0),
                  12'($urandom_range(0, 31)),
                  ($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
